bpu: RTL

Branch prediction unit for the Core101 front end. It holds a direct-mapped table of 2-bit saturating counters indexed by PC. It answers fetch-stage lookups with a registered taken/not-taken prediction and a branch target (PC + immediate). It is trained by the branch resolver's prediction/correction pair from the execute stage. It is the producer of the prediction bit the branch resolver consumes, and the consumer of the correction the resolver produces.

---
 rtl/bpu.sv | 116 +++++++++++
 1 files changed

// File: rtl/bpu.sv
// Core101 branch prediction unit: direct-mapped 2-bit counter table,
// registered lookup with bypass from a same-cycle training update.
module bpu #(
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 6
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  bpu_lookup_valid_in,
   input  logic [DATA_WIDTH-1:0] bpu_lookup_pc_in,
   input  logic [DATA_WIDTH-1:0] bpu_lookup_imm_in,
   input  logic                  bpu_update_valid_in,
   input  logic [DATA_WIDTH-1:0] bpu_update_pc_in,
   input  logic                  bpu_update_prediction_in,
   input  logic                  bpu_update_correction_in,
   output logic                  bpu_ready_out,
   output logic                  bpu_pred_valid_out,
   output logic                  bpu_prediction_out,
   output logic [DATA_WIDTH-1:0] bpu_target_out,
   output logic [15:0]           bpu_mispredict_count_out
);

   localparam int ENTRIES = 1 << INDEX_WIDTH;

   typedef enum logic {INIT, READY} state_e;

   state_e                  state_q, state_d;
   logic [INDEX_WIDTH-1:0]  ptr_q, ptr_d;
   logic [1:0]              tbl_q [ENTRIES];
   logic                    pred_valid_q, pred_q;
   logic [DATA_WIDTH-1:0]   target_q;
   logic [15:0]             miss_q;

   logic                    init_we, ready, lk_acc, up_acc, outcome;
   logic [INDEX_WIDTH-1:0]  lk_idx, up_idx;
   logic [1:0]              up_old, up_new;
   logic                    pred_d;
   logic                    unused_pc_bits;

   assign lk_idx  = bpu_lookup_pc_in[INDEX_WIDTH+1:2];
   assign up_idx  = bpu_update_pc_in[INDEX_WIDTH+1:2];
   assign ready   = (state_q == READY);
   assign lk_acc  = ready & bpu_lookup_valid_in;
   assign up_acc  = ready & bpu_update_valid_in;
   assign outcome = bpu_update_prediction_in ^ bpu_update_correction_in;
   assign up_old  = tbl_q[up_idx];

   assign unused_pc_bits = ^{bpu_lookup_pc_in[DATA_WIDTH-1:INDEX_WIDTH+2],
                             bpu_lookup_pc_in[1:0],
                             bpu_update_pc_in[DATA_WIDTH-1:INDEX_WIDTH+2],
                             bpu_update_pc_in[1:0]};

   always_comb begin
      up_new = up_old;
      if (outcome) begin
         if (up_old != 2'b11) up_new = up_old + 2'd1;
      end else begin
         if (up_old != 2'b00) up_new = up_old - 2'd1;
      end
   end

   // same-index update wins so the lookup sees the post-update counter
   always_comb begin
      pred_d = tbl_q[lk_idx][1];
      if (up_acc && (up_idx == lk_idx)) pred_d = up_new[1];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      init_we = 1'b0;
      case (state_q)
         INIT: begin
            init_we = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            if (ptr_q == {INDEX_WIDTH{1'b1}}) state_d = READY;
         end
         READY: state_d = READY;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= INIT;
         ptr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_q       <= 1'b0;
         target_q     <= '0;
         miss_q       <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         pred_valid_q <= lk_acc;
         if (lk_acc) begin
            pred_q   <= pred_d;
            target_q <= bpu_lookup_pc_in + bpu_lookup_imm_in;
         end
         if (up_acc && bpu_update_correction_in && (miss_q != 16'hFFFF))
            miss_q <= miss_q + 16'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         if (init_we)     tbl_q[ptr_q]  <= 2'b01;
         else if (up_acc) tbl_q[up_idx] <= up_new;
      end
   end

   assign bpu_ready_out            = ready;
   assign bpu_pred_valid_out       = pred_valid_q;
   assign bpu_prediction_out       = pred_q;
   assign bpu_target_out           = target_q;
   assign bpu_mispredict_count_out = miss_q;

endmodule
